// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage pipeline.
// Generates PC / pipeline-register enables and flushes for memory waits,
// taken branches, load-use and MD-unit stalls, and the EX forwarding selects.
// Optional feature macro: HAZ_PERF_EN adds stall_cycles / flush_cycles counters.
module pipe_hazard_ctrl #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10,
   parameter int unsigned CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rs_id,
   input  logic [4:0] rt_id,
   input  logic       use_rs_id,
   input  logic       use_rt_id,
   input  logic       md_use_id,
   input  logic [4:0] rs_ex,
   input  logic [4:0] rt_ex,
   input  logic [4:0] rd_ex,
   input  logic       regwrite_ex,
   input  logic       memread_ex,
   input  logic       md_start_ex,
   input  logic       md_op_ex,
   input  logic       branch_taken_ex,
   input  logic [4:0] rd_mem,
   input  logic       regwrite_mem,
   input  logic       dmem_req_mem,
   input  logic       dmem_ack,
   input  logic [4:0] rd_wb,
   input  logic       regwrite_wb,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       idex_en,
   output logic       exmem_en,
   output logic       memwb_en,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic       exmem_flush,
   output logic       memwb_flush,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b,
`ifdef HAZ_PERF_EN
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_cycles,
`endif
   output logic       md_busy
);

   typedef enum logic [0:0] {StRun, StMdBusy} state_e;

   localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic memwait, loaduse, mdstall, busy;

   assign busy    = (state_q == StMdBusy);
   assign memwait = dmem_req_mem & ~dmem_ack;
   assign loaduse = memread_ex & regwrite_ex & (rd_ex != 5'd0) &
                    ((use_rs_id & (rs_id == rd_ex)) | (use_rt_id & (rt_id == rd_ex)));
   assign mdstall = busy & md_use_id;

   // MEM result is newer than WB, so it wins when both match.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] mem_rd, input logic mem_we,
                                          input logic [4:0] wb_rd,  input logic wb_we);
      logic [1:0] sel;
      sel = 2'b00;
      if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
         sel = 2'b10;
      end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   // Prioritised stall/flush decode; everything is held low while in reset.
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
      md_busy     = 1'b0;
      if (rst) begin
         md_busy = busy;
         fwd_a   = fwd_sel(rs_ex, rd_mem, regwrite_mem, rd_wb, regwrite_wb);
         fwd_b   = fwd_sel(rt_ex, rd_mem, regwrite_mem, rd_wb, regwrite_wb);
         if (memwait) begin
            // Freeze the front of the pipe, drain a bubble into WB.
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
         end else if (branch_taken_ex) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (loaduse || mdstall) begin
            // Hold IF/ID, inject a bubble into EX, let the back end advance.
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            idex_flush = 1'b1;
         end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end
      end
   end

   // MD sequencer next state: busy for counter value N-1 down to 0 inclusive.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StRun: begin
            if (md_start_ex && idex_en) begin
               state_d = StMdBusy;
               cnt_d   = md_op_ex ? DivLoad : MulLoad;
            end
         end
         StMdBusy: begin
            if (cnt_q == '0) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StRun;
      endcase
   end

   // MD state and countdown registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZ_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_cycles_q, flush_cycles_d;

   // Saturating event counters.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_cycles_d = flush_cycles_q;
      if (!pc_en && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (ifid_flush && (flush_cycles_q != 32'hFFFF_FFFF)) begin
         flush_cycles_d = flush_cycles_q + 32'd1;
      end
   end

   // Counter registers, cleared and frozen by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q <= '0;
         flush_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_cycles_q <= flush_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
   logic       use_rs_id, use_rt_id, md_use_id, regwrite_ex, memread_ex;
   logic       md_start_ex, md_op_ex, branch_taken_ex, regwrite_mem;
   logic       dmem_req_mem, dmem_ack, regwrite_wb;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic [1:0] fwd_a, fwd_b;
   logic       md_busy;
`ifdef HAZ_PERF_EN
   logic [31:0] stall_cycles, flush_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem, memwb flushes}
   localparam logic [8:0] CtlOff    = 9'b00000_0000;
   localparam logic [8:0] CtlRun    = 9'b11111_0000;
   localparam logic [8:0] CtlStall  = 9'b00111_0100;
   localparam logic [8:0] CtlBranch = 9'b11111_1100;
   localparam logic [8:0] CtlWait   = 9'b00001_0001;

   logic [8:0] ctl;
   assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush};

   pipe_hazard_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .rs_id           (rs_id),
      .rt_id           (rt_id),
      .use_rs_id       (use_rs_id),
      .use_rt_id       (use_rt_id),
      .md_use_id       (md_use_id),
      .rs_ex           (rs_ex),
      .rt_ex           (rt_ex),
      .rd_ex           (rd_ex),
      .regwrite_ex     (regwrite_ex),
      .memread_ex      (memread_ex),
      .md_start_ex     (md_start_ex),
      .md_op_ex        (md_op_ex),
      .branch_taken_ex (branch_taken_ex),
      .rd_mem          (rd_mem),
      .regwrite_mem    (regwrite_mem),
      .dmem_req_mem    (dmem_req_mem),
      .dmem_ack        (dmem_ack),
      .rd_wb           (rd_wb),
      .regwrite_wb     (regwrite_wb),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .idex_en         (idex_en),
      .exmem_en        (exmem_en),
      .memwb_en        (memwb_en),
      .ifid_flush      (ifid_flush),
      .idex_flush      (idex_flush),
      .exmem_flush     (exmem_flush),
      .memwb_flush     (memwb_flush),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b),
`ifdef HAZ_PERF_EN
      .stall_cycles    (stall_cycles),
      .flush_cycles    (flush_cycles),
`endif
      .md_busy         (md_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rs_id = '0; rt_id = '0; use_rs_id = 0; use_rt_id = 0; md_use_id = 0;
      rs_ex = '0; rt_ex = '0; rd_ex = '0; regwrite_ex = 0; memread_ex = 0;
      md_start_ex = 0; md_op_ex = 0; branch_taken_ex = 0;
      rd_mem = '0; regwrite_mem = 0; dmem_req_mem = 0; dmem_ack = 0;
      rd_wb = '0; regwrite_wb = 0;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      // Forwarding match present during reset must still yield 00.
      rs_ex = 5'd5; rd_mem = 5'd5; regwrite_mem = 1;
      #1;
      check("rst_ctl", 32'(ctl), 32'(CtlOff));
      check("rst_fwd_a", 32'(fwd_a), 32'd0);
      check("rst_busy", 32'(md_busy), 32'd0);
      tick();
      rst = 1'b1;
      clear_inputs();
      #1;
      check("idle_ctl", 32'(ctl), 32'(CtlRun));

      // Load-use on rs.
      tick();
      memread_ex = 1; regwrite_ex = 1; rd_ex = 5'd8; rs_id = 5'd8; use_rs_id = 1;
      #1;
      check("lu_rs_ctl", 32'(ctl), 32'(CtlStall));
      rd_ex = 5'd0; rs_id = 5'd0;
      #1;
      check("lu_r0_ctl", 32'(ctl), 32'(CtlRun));
      // Load-use on rt, and an unused rt that matches.
      rd_ex = 5'd8; rs_id = 5'd3; rt_id = 5'd8; use_rt_id = 1;
      #1;
      check("lu_rt_ctl", 32'(ctl), 32'(CtlStall));
      use_rt_id = 0;
      #1;
      check("lu_rt_unused", 32'(ctl), 32'(CtlRun));
      // Branch beats load-use.
      use_rt_id = 1; branch_taken_ex = 1;
      #1;
      check("br_lu_ctl", 32'(ctl), 32'(CtlBranch));
      // Memory wait beats branch.
      dmem_req_mem = 1;
      #1;
      check("mw_br_ctl", 32'(ctl), 32'(CtlWait));
      dmem_ack = 1;
      #1;
      check("ack_br_ctl", 32'(ctl), 32'(CtlBranch));
      clear_inputs();

      // Forwarding.
      rs_ex = 5'd5; rd_mem = 5'd5; rd_wb = 5'd5; regwrite_mem = 1; regwrite_wb = 1;
      #1;
      check("fwd_a_mem", 32'(fwd_a), 32'd2);
      check("fwd_b_none", 32'(fwd_b), 32'd0);
      regwrite_mem = 0;
      #1;
      check("fwd_a_wb", 32'(fwd_a), 32'd1);
      rs_ex = 5'd0; rd_mem = 5'd0; rd_wb = 5'd0; rt_ex = 5'd7;
      #1;
      check("fwd_a_r0", 32'(fwd_a), 32'd0);
      rd_wb = 5'd7; rd_mem = 5'd7; regwrite_mem = 1;
      #1;
      check("fwd_b_mem", 32'(fwd_b), 32'd2);
      clear_inputs();

      // Divide with a dependent instruction waiting in ID.
      tick();
      md_start_ex = 1; md_op_ex = 1;
      #1;
      check("div_pre_busy", 32'(md_busy), 32'd0);
      tick();
      clear_inputs();
      md_use_id = 1;
      for (int i = 0; i < 12; i++) begin
         #1;
         check($sformatf("div_busy_%0d", i), 32'(md_busy), (i < 10) ? 32'd1 : 32'd0);
         check($sformatf("div_ctl_%0d", i), 32'(ctl),
               (i < 10) ? 32'(CtlStall) : 32'(CtlRun));
         tick();
      end
      clear_inputs();

      // Multiply with a 3-cycle memory wait overlapping the countdown.
      md_start_ex = 1;
      #1;
      tick();
      clear_inputs();
      for (int i = 0; i < 7; i++) begin
         dmem_req_mem = (i < 3);
         #1;
         check($sformatf("mul_busy_%0d", i), 32'(md_busy), (i < 5) ? 32'd1 : 32'd0);
         check($sformatf("mul_ctl_%0d", i), 32'(ctl),
               (i < 3) ? 32'(CtlWait) : 32'(CtlRun));
         tick();
      end
      clear_inputs();

      // MD start blocked by a memory wait must not launch.
      md_start_ex = 1; dmem_req_mem = 1;
      #1;
      tick();
      clear_inputs();
      #1;
      check("mw_nostart", 32'(md_busy), 32'd0);

      // Reset mid-multiply at counter value 2.
      tick();
      md_start_ex = 1;
      #1;
      tick();
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rstmul_busy", 32'(md_busy), 32'd0);
      check("rstmul_ctl", 32'(ctl), 32'(CtlOff));
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("post_rst_ctl", 32'(ctl), 32'(CtlRun));
      tick();
      check("post_rst_busy", 32'(md_busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage pipelined CPU. Drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Sequences stalls for load-use hazards, the multi-cycle multiply/divide unit and data-memory wait states. Squashes wrong-path instructions on a taken branch and produces the EX-stage operand forwarding selects.

Parameters:
MUL_CYCLES, 5, total multiply latency in cycles (>=2)
DIV_CYCLES, 10, total divide latency in cycles (>=2)
CNT_W, 4, width of the MD countdown counter; must hold DIV_CYCLES-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
rs_id, rt_id  in  5  source register numbers of the instruction in ID
use_rs_id, use_rt_id  in  1  ID instruction actually reads rs / rt
md_use_id  in  1  ID instruction reads HI/LO or issues an MD operation
rs_ex, rt_ex  in  5  source register numbers in EX
rd_ex  in  5  destination register in EX
regwrite_ex, memread_ex  in  1  EX instruction writes a register / is a load
md_start_ex  in  1  EX instruction starts an MD operation
md_op_ex  in  1  0 = multiply, 1 = divide
branch_taken_ex  in  1  branch/jump resolved taken in EX
rd_mem, regwrite_mem  in  5/1  MEM-stage destination register and write flag
dmem_req_mem, dmem_ack  in  1  MEM-stage memory access request / completion
rd_wb, regwrite_wb  in  5/1  WB-stage destination register and write flag
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register load enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  load a bubble (all-zero control word)
fwd_a, fwd_b  out  2  EX operand select: 00 = register file, 01 = WB, 10 = MEM
md_busy  out  1  MD unit is occupied

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to RUN and the MD counter is cleared.
  - While rst=0: all *_en=0, all *_flush=0, fwd_a=fwd_b=00, md_busy=0.
  - A reset during MD_BUSY aborts the operation immediately.
- The FSM has two states, RUN and MD_BUSY. md_busy = (state==MD_BUSY).
  - RUN -> MD_BUSY: when md_start_ex=1 and idex_en=1. The counter loads MUL_CYCLES-1 or DIV_CYCLES-1, selected by md_op_ex.
  - MD_BUSY: the counter decrements every cycle, memory stalls included.
  - MD_BUSY -> RUN: on the cycle after the counter reaches 0. Total busy time is exactly MUL_CYCLES or DIV_CYCLES cycles.
  - md_start_ex in MD_BUSY cannot occur because of the md stall below; if it does occur, it is ignored.
- Stall and flush conditions:
  - memwait = dmem_req_mem & ~dmem_ack
  - loaduse = memread_ex & regwrite_ex & (rd_ex!=0) & ((use_rs_id & rs_id==rd_ex) | (use_rt_id & rt_id==rd_ex))
  - mdstall = md_busy & md_use_id
- Priority, highest first:
  1. memwait: pc_en, ifid_en, idex_en and exmem_en are all 0; memwb_en=1 with memwb_flush=1 (bubble into WB). Any other condition present in the same cycle is held and re-evaluated later.
  2. branch_taken_ex: pc_en=1, ifid_flush=1, idex_flush=1. This overrides loaduse and mdstall, because the ID instruction is squashed.
  3. loaduse or mdstall: pc_en=0, ifid_en=0, idex_flush=1, and EX/MEM and MEM/WB advance.
  4. Otherwise: all enables 1, all flushes 0.
- exmem_flush is 0 in every case listed; it is reserved for exceptions.
- Forwarding (combinational, applied to fwd_a with rs_ex and to fwd_b with rt_ex):
  - 10 if regwrite_mem & rd_mem!=0 & rd_mem matches.
  - Otherwise 01 if regwrite_wb & rd_wb!=0 & rd_wb matches.
  - Otherwise 00.
  - MEM has priority over WB.
- Latency: all stall, flush and forward outputs are combinational from the inputs and the current state, so they take effect in the same cycle. Only the FSM and the counter are registered.

Optional Feature:
HAZ_PERF_EN:
- When defined, adds output ports stall_cycles[31:0] and flush_cycles[31:0].
  - stall_cycles counts cycles with pc_en=0.
  - flush_cycles counts cycles with ifid_flush=1.
  - Both are cleared by rst, saturate at 32'hFFFFFFFF, and are frozen while rst=0.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: memread_ex=1, regwrite_ex=1, rd_ex=8, rs_id=8, use_rs_id=1 -> pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle. With rd_ex=0 instead -> no stall.
- Divide: md_start_ex=1, md_op_ex=1 -> md_busy=1 for exactly 10 cycles. With md_use_id=1 throughout -> pc_en=0 for those 10 cycles, then RUN.
- Branch plus load-use in the same cycle: branch_taken_ex=1 -> pc_en=1, ifid_flush=1, idex_flush=1, and no stall.
- Memory wait: dmem_req_mem=1 with dmem_ack low for 3 cycles -> pc_en, ifid_en, idex_en, exmem_en all 0 and memwb_flush=1 for 3 cycles. An MD countdown running concurrently still decrements.
- Forwarding: rs_ex=rd_mem=rd_wb=5, both write flags 1 -> fwd_a=10. Clear regwrite_mem -> fwd_a=01. rs_ex=0 -> fwd_a=00.
- Reset mid-multiply: assert rst=0 at counter value 2 -> md_busy=0 immediately. After release, state is RUN and all enables are 1.
